// File: rtl/alu_pkg.sv
// Shared ALU control encodings, RV32I opcodes and the decoded-field bundle
// used by the ID/EX decoder, the EX-stage ALU and the hazard unit.
package alu_pkg;

  localparam int XLEN_C      = 32;
  localparam int RF_ADDR_W_C = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] ASEL_RS1  = 2'b00;
  localparam logic [1:0] ASEL_ZERO = 2'b01;
  localparam logic [1:0] ASEL_PC   = 2'b10;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]             alu_ctrl;
    logic [1:0]             a_sel;
    logic                   b_imm;
    logic [XLEN_C-1:0]      imm;
    logic [RF_ADDR_W_C-1:0] rd;
    logic                   we;
    logic                   illegal;
  } dec_t;

  // funct3 -> ALU op for register/immediate arithmetic; alt selects sub/sra.
  function automatic logic [3:0] alu_base_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode_comb.sv
// Pure combinational RV32I decode: instruction word -> ALU control fields.
// Undecodable words produce an all-zero bundle with only the illegal flag set.
module alu_ctrl_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_sh;
  logic        legal;
  logic        writes;
  logic        has_rd;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd_f   = instr[11:7];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    writes = 1'b1;
    has_rd = 1'b1;
    case (opcode)
      OPC_OP: begin
        legal        = (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == 3'b000 || f3 == 3'b101));
        dec.alu_ctrl = alu_base_op(f3, f7[5]);
      end
      OPC_OP_IMM: begin
        dec.b_imm = 1'b1;
        if (f3 == 3'b001) begin
          legal        = (f7 == F7_BASE);
          dec.alu_ctrl = ALU_SLL;
          dec.imm      = imm_sh;
        end else if (f3 == 3'b101) begin
          legal        = (f7 == F7_BASE) || (f7 == F7_ALT);
          dec.alu_ctrl = alu_base_op(f3, f7[5]);
          dec.imm      = imm_sh;
        end else begin
          dec.alu_ctrl = alu_base_op(f3, 1'b0);
          dec.imm      = imm_i;
        end
      end
      OPC_LOAD: begin
        dec.b_imm = 1'b1;
        dec.imm   = imm_i;
      end
      OPC_STORE: begin
        dec.b_imm = 1'b1;
        dec.imm   = imm_s;
        writes    = 1'b0;
        has_rd    = 1'b0;
      end
      OPC_BRANCH: begin
        // Branch compare: eq/ne via subtract, lt/ge signed, ltu/geu unsigned.
        legal   = (f3[2:1] != 2'b01);
        writes  = 1'b0;
        has_rd  = 1'b0;
        dec.imm = imm_b;
        if (!f3[2])
          dec.alu_ctrl = ALU_SUB;
        else if (!f3[1])
          dec.alu_ctrl = ALU_SLT;
        else
          dec.alu_ctrl = ALU_SLTU;
      end
      OPC_LUI: begin
        dec.a_sel = ASEL_ZERO;
        dec.b_imm = 1'b1;
        dec.imm   = imm_u;
      end
      OPC_AUIPC: begin
        dec.a_sel = ASEL_PC;
        dec.b_imm = 1'b1;
        dec.imm   = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU computes the link value pc + 4; the target comes from elsewhere.
        dec.a_sel = ASEL_PC;
        dec.b_imm = 1'b1;
        dec.imm   = 32'd4;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else begin
      dec.rd = has_rd ? rd_f : 5'd0;
      dec.we = writes && (rd_f != 5'd0);
    end
  end

endmodule

// File: rtl/alu_ctrl_decoder.sv
// ID/EX register for the ALU control interface: decodes the ID instruction and
// holds it for EX behind a valid/ready handshake with stall and flush.
module alu_ctrl_decoder
  import alu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [31:0]          id_instr,
  output logic                 id_ready,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [3:0]           ex_alu_ctrl,
  output logic [1:0]           ex_a_sel,
  output logic                 ex_b_imm,
  output logic [XLEN-1:0]      ex_imm,
  output logic [RF_ADDR_W-1:0] ex_rd,
  output logic                 ex_we,
  output logic                 ex_illegal
);

  dec_t dec;
  dec_t ex_dec_q, ex_dec_d;
  logic ex_valid_q, ex_valid_d;
  logic load;

  alu_ctrl_decode_comb u_decode (
    .instr (id_instr),
    .dec   (dec)
  );

  assign id_ready = ~ex_valid_q | ex_ready;
  assign load     = id_valid & id_ready;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_dec_d   = ex_dec_q;
    if (load) begin
      ex_dec_d   = dec;
      ex_valid_d = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
    // Flush only kills validity; a field update on the same edge is harmless.
    if (flush)
      ex_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_dec_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_dec_q   <= ex_dec_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_alu_ctrl = ex_dec_q.alu_ctrl;
  assign ex_a_sel    = ex_dec_q.a_sel;
  assign ex_b_imm    = ex_dec_q.b_imm;
  assign ex_imm      = ex_dec_q.imm;
  assign ex_rd       = ex_dec_q.rd;
  assign ex_we       = ex_dec_q.we;
  assign ex_illegal  = ex_dec_q.illegal;

endmodule
